// File: rtl/itype_ctrl_fsm.sv
// rtl/itype_ctrl_fsm.sv - multi-cycle control sequencer for the I-type datapath
//
// Sequences fetch, decode, execute (immediate operand), optional data load and
// writeback. Illegal encodings and memory-handshake timeouts enter a sticky trap
// that only reset clears.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   run                   enable, sampled in IDLE and WRITEBACK
//   instr                 IR contents, stable from DECODE onward
//   imem_req / imem_ack   instruction fetch handshake (ack = data valid)
//   ir_we                 IR load strobe (FETCH & imem_ack)
//   dmem_req / dmem_ack   data load handshake
//   alu_ctrl, alu_src_imm ALU operation select, operand B = immediate
//   reg_we, wb_sel        register write enable, writeback source
//   pc_we, pc_sel_jalr    PC update strobe, PC source (JALR target vs PC+4)
//   trap, trap_cause      sticky trap flag and its cause
//   retire_cnt            retired-instruction count (wraps)

module itype_ctrl_fsm #(
    parameter int TIMEOUT = 16,
    parameter int RCNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [31:0]       instr,
    output logic              imem_req,
    input  logic              imem_ack,
    output logic              ir_we,
    output logic              dmem_req,
    input  logic              dmem_ack,
    output logic [3:0]        alu_ctrl,
    output logic              alu_src_imm,
    output logic              reg_we,
    output logic [1:0]        wb_sel,
    output logic              pc_we,
    output logic              pc_sel_jalr,
    output logic              trap,
    output logic [1:0]        trap_cause,
    output logic [RCNT_W-1:0] retire_cnt
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEMORY    = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;
    localparam logic [2:0] S_TRAP      = 3'd6;

    localparam logic [1:0] C_NONE  = 2'd0;
    localparam logic [1:0] C_OPIMM = 2'd1;
    localparam logic [1:0] C_LOAD  = 2'd2;
    localparam logic [1:0] C_JALR  = 2'd3;

    localparam logic [1:0] CAUSE_FETCH   = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
    localparam logic [1:0] CAUSE_LOAD    = 2'b11;

    logic [2:0]    state, state_nx;
    logic [1:0]    cls, cls_nx;
    logic [1:0]    cause_nx;
    logic [CW-1:0] wait_cnt, wait_nx;
    logic [1:0]    dec_cls;
    logic          wait_last;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [3:0] opimm_alu;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // rs1 and immediate bits feed the datapath directly; nothing to decide here
    logic unused_instr;
    assign unused_instr = ^instr[24:15];

    // instr[30] distinguishes SRAI from SRLI; only meaningful for funct3 101
    assign opimm_alu = {instr[30] & (funct3 == 3'b101), funct3};

    // Last allowed wait cycle: counter starts at 0 on the first FETCH/MEMORY cycle
    assign wait_last = (wait_cnt == CW'(TIMEOUT - 1));

    // Instruction classification; C_NONE means illegal
    always_comb begin
        dec_cls = C_NONE;
        case (opcode)
            7'b0010011: begin
                case (funct3)
                    3'b001:  dec_cls = (funct7 == 7'b0000000) ? C_OPIMM : C_NONE;
                    3'b101:  dec_cls = (funct7 == 7'b0000000 || funct7 == 7'b0100000)
                                       ? C_OPIMM : C_NONE;
                    default: dec_cls = C_OPIMM;
                endcase
            end
            7'b0000011: begin
                case (funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: dec_cls = C_LOAD;
                    default:                                dec_cls = C_NONE;
                endcase
            end
            7'b1100111: dec_cls = (funct3 == 3'b000) ? C_JALR : C_NONE;
            default:    dec_cls = C_NONE;
        endcase
    end

    // Next-state logic. The wait counter defaults to 0 so every entry into
    // FETCH or MEMORY starts a fresh count.
    always_comb begin
        state_nx = state;
        cls_nx   = cls;
        cause_nx = trap_cause;
        wait_nx  = '0;
        case (state)
            S_IDLE: begin
                if (run) state_nx = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    state_nx = S_DECODE;
                end else if (wait_last) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_FETCH;
                end else begin
                    wait_nx = wait_cnt + CW'(1);
                end
            end
            S_DECODE: begin
                cls_nx = dec_cls;
                if (dec_cls == C_NONE) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_ILLEGAL;
                end else begin
                    state_nx = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                state_nx = (cls == C_LOAD) ? S_MEMORY : S_WRITEBACK;
            end
            S_MEMORY: begin
                if (dmem_ack) begin
                    state_nx = S_WRITEBACK;
                end else if (wait_last) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_LOAD;
                end else begin
                    wait_nx = wait_cnt + CW'(1);
                end
            end
            S_WRITEBACK: begin
                state_nx = run ? S_FETCH : S_IDLE;
            end
            S_TRAP: begin
                state_nx = S_TRAP;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cls        <= C_NONE;
            wait_cnt   <= '0;
            trap_cause <= 2'b00;
            retire_cnt <= '0;
        end else begin
            state      <= state_nx;
            cls        <= cls_nx;
            wait_cnt   <= wait_nx;
            trap_cause <= cause_nx;
            if (state == S_WRITEBACK) retire_cnt <= retire_cnt + RCNT_W'(1);
        end
    end

    // Outputs decode from state and the latched class; ir_we is the only Mealy term
    always_comb begin
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        dmem_req    = 1'b0;
        alu_ctrl    = 4'b0000;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 2'b00;
        pc_we       = 1'b0;
        pc_sel_jalr = 1'b0;
        trap        = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
            end
            S_EXECUTE: begin
                alu_src_imm = 1'b1;
                alu_ctrl    = (cls == C_OPIMM) ? opimm_alu : 4'b0000;
            end
            S_MEMORY: begin
                dmem_req    = 1'b1;
                alu_src_imm = 1'b1;
            end
            S_WRITEBACK: begin
                alu_src_imm = 1'b1;
                alu_ctrl    = (cls == C_OPIMM) ? opimm_alu : 4'b0000;
                pc_we       = 1'b1;
                reg_we      = (rd != 5'd0);
                pc_sel_jalr = (cls == C_JALR);
                case (cls)
                    C_LOAD:  wb_sel = 2'b01;
                    C_JALR:  wb_sel = 2'b10;
                    default: wb_sel = 2'b00;
                endcase
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_itype_ctrl_fsm.sv
// tb/tb_itype_ctrl_fsm.sv - directed self-checking bench for itype_ctrl_fsm

module tb_itype_ctrl_fsm;

    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_SRAI  = 32'h4021D193;
    localparam logic [31:0] I_LW    = 32'h0000A103;
    localparam logic [31:0] I_JALR1 = 32'h000100E7;
    localparam logic [31:0] I_JALR0 = 32'h00010067;
    localparam logic [31:0] I_BAD   = 32'h40109093;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [31:0] instr;
    logic        imem_req, imem_ack, ir_we;
    logic        dmem_req, dmem_ack;
    logic [3:0]  alu_ctrl;
    logic        alu_src_imm, reg_we, pc_we, pc_sel_jalr, trap;
    logic [1:0]  wb_sel, trap_cause;
    logic [31:0] retire_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;
    int nreq    = 0;

    itype_ctrl_fsm #(.TIMEOUT(16), .RCNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .instr       (instr),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .ir_we       (ir_we),
        .dmem_req    (dmem_req),
        .dmem_ack    (dmem_ack),
        .alu_ctrl    (alu_ctrl),
        .alu_src_imm (alu_src_imm),
        .reg_we      (reg_we),
        .wb_sel      (wb_sel),
        .pc_we       (pc_we),
        .pc_sel_jalr (pc_sel_jalr),
        .trap        (trap),
        .trap_cause  (trap_cause),
        .retire_cnt  (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the edge, outputs checked 1 unit later
    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_imem_req"}, 32'(imem_req), 0);
        chk({tag, "_ir_we"}, 32'(ir_we), 0);
        chk({tag, "_dmem_req"}, 32'(dmem_req), 0);
        chk({tag, "_alu_ctrl"}, 32'(alu_ctrl), 0);
        chk({tag, "_alu_src"}, 32'(alu_src_imm), 0);
        chk({tag, "_reg_we"}, 32'(reg_we), 0);
        chk({tag, "_wb_sel"}, 32'(wb_sel), 0);
        chk({tag, "_pc_we"}, 32'(pc_we), 0);
        chk({tag, "_pc_jalr"}, 32'(pc_sel_jalr), 0);
        chk({tag, "_trap"}, 32'(trap), 0);
        chk({tag, "_cause"}, 32'(trap_cause), 0);
        chk({tag, "_retire"}, retire_cnt, 0);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; instr = 32'h0; imem_ack = 1'b0; dmem_ack = 1'b0;
        #3;
        chk_quiet("reset");

        // ADDI x1,x0,5 with immediate acks
        tick;
        rst_n = 1'b1; run = 1'b1; instr = I_ADDI; imem_ack = 1'b1; dmem_ack = 1'b1;
        #1;
        chk("idle_req", 32'(imem_req), 0);
        tick; #1;
        chk("addi_fetch_req", 32'(imem_req), 1);
        chk("addi_fetch_irwe", 32'(ir_we), 1);
        tick; #1;
        chk("addi_dec_req", 32'(imem_req), 0);
        chk("addi_dec_src", 32'(alu_src_imm), 0);
        tick; #1;
        chk("addi_ex_src", 32'(alu_src_imm), 1);
        chk("addi_ex_alu", 32'(alu_ctrl), 0);
        chk("addi_ex_regwe", 32'(reg_we), 0);
        tick; #1;
        chk("addi_wb_regwe", 32'(reg_we), 1);
        chk("addi_wb_sel", 32'(wb_sel), 0);
        chk("addi_wb_alu", 32'(alu_ctrl), 0);
        chk("addi_wb_pcwe", 32'(pc_we), 1);
        chk("addi_wb_jalr", 32'(pc_sel_jalr), 0);

        // SRAI x3,x3,2
        tick; instr = I_SRAI; #1;
        chk("srai_fetch_req", 32'(imem_req), 1);
        chk("retire_1", retire_cnt, 1);
        tick; tick; #1;
        chk("srai_ex_alu", 32'(alu_ctrl), 32'hD);
        tick; #1;
        chk("srai_wb_alu", 32'(alu_ctrl), 32'hD);
        chk("srai_wb_regwe", 32'(reg_we), 1);
        chk("srai_wb_sel", 32'(wb_sel), 0);

        // LW x2,0(x1) with dmem_ack delayed 3 cycles
        tick; instr = I_LW; dmem_ack = 1'b0; #1;
        t0 = cyc;
        chk("lw_fetch_req", 32'(imem_req), 1);
        chk("retire_2", retire_cnt, 2);
        tick; tick; #1;
        chk("lw_ex_alu", 32'(alu_ctrl), 0);
        chk("lw_ex_dreq", 32'(dmem_req), 0);
        nreq = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (i == 3) dmem_ack = 1'b1;
            #1;
            if (dmem_req) nreq++;
            chk("lw_mem_src", 32'(alu_src_imm), 1);
        end
        tick; #1;
        if (dmem_req) nreq++;
        chk("lw_dreq_cycles", 32'(nreq), 4);
        chk("lw_wb_sel", 32'(wb_sel), 1);
        chk("lw_wb_regwe", 32'(reg_we), 1);
        chk("lw_wb_pcwe", 32'(pc_we), 1);
        chk("lw_cycles", 32'(cyc - t0 + 1), 8);

        // JALR x1,0(x2)
        tick; instr = I_JALR1; #1;
        tick; tick; tick; #1;
        chk("jalr1_wb_jalr", 32'(pc_sel_jalr), 1);
        chk("jalr1_wb_sel", 32'(wb_sel), 2);
        chk("jalr1_wb_regwe", 32'(reg_we), 1);
        chk("jalr1_wb_pcwe", 32'(pc_we), 1);

        // JALR x0,0(x2): no register write; run dropped at writeback
        tick; instr = I_JALR0; #1;
        tick; tick; tick; run = 1'b0; #1;
        chk("jalr0_wb_regwe", 32'(reg_we), 0);
        chk("jalr0_wb_jalr", 32'(pc_sel_jalr), 1);
        chk("jalr0_wb_pcwe", 32'(pc_we), 1);
        tick; #1;
        chk("runoff_idle_req", 32'(imem_req), 0);
        chk("retire_5", retire_cnt, 5);
        tick; #1;
        chk("runoff_idle_req2", 32'(imem_req), 0);

        // Illegal SLLI encoding traps after DECODE
        run = 1'b1; instr = I_BAD;
        tick; #1;
        chk("bad_fetch_req", 32'(imem_req), 1);
        tick; #1;
        chk("bad_dec_regwe", 32'(reg_we), 0);
        chk("bad_dec_pcwe", 32'(pc_we), 0);
        tick; #1;
        chk("bad_trap", 32'(trap), 1);
        chk("bad_cause", 32'(trap_cause), 2);
        chk("bad_trap_regwe", 32'(reg_we), 0);
        chk("bad_trap_pcwe", 32'(pc_we), 0);
        for (int i = 0; i < 20; i++) begin
            tick; #1;
            chk("bad_sticky_trap", 32'(trap), 1);
            chk("bad_sticky_req", 32'(imem_req | dmem_req | pc_we | reg_we), 0);
        end
        chk("bad_retire", retire_cnt, 5);

        // Fetch timeout: no ack for 16 FETCH cycles
        rst_n = 1'b0; #1;
        chk("rst_trap_clr", 32'(trap), 0);
        chk("rst_cause_clr", 32'(trap_cause), 0);
        rst_n = 1'b1; imem_ack = 1'b0; instr = I_ADDI; run = 1'b1;
        tick; #1;
        chk("fto_fetch1", 32'(imem_req), 1);
        for (int k = 2; k <= 16; k++) begin
            tick; #1;
            chk("fto_fetch_req", 32'(imem_req), 1);
            chk("fto_no_trap", 32'(trap), 0);
        end
        tick; #1;
        chk("fto_trap", 32'(trap), 1);
        chk("fto_cause", 32'(trap_cause), 1);
        chk("fto_req_off", 32'(imem_req), 0);

        // Ack on the 16th FETCH cycle wins
        rst_n = 1'b0; #1;
        rst_n = 1'b1;
        tick; #1;
        for (int k = 2; k <= 15; k++) begin
            tick; #1;
        end
        chk("ack16_no_trap", 32'(trap), 0);
        tick; imem_ack = 1'b1; #1;
        chk("ack16_irwe", 32'(ir_we), 1);
        tick; #1;
        chk("ack16_dec_req", 32'(imem_req), 0);
        chk("ack16_dec_trap", 32'(trap), 0);
        chk("ack16_dec_src", 32'(alu_src_imm), 0);
        tick; #1;
        chk("ack16_ex_src", 32'(alu_src_imm), 1);
        tick; #1;
        chk("ack16_wb_pcwe", 32'(pc_we), 1);

        // Reset asserted during MEMORY
        tick; instr = I_LW; dmem_ack = 1'b0; #1;
        tick; tick; tick; #1;
        chk("rstmem_dreq", 32'(dmem_req), 1);
        chk("rstmem_retire", retire_cnt, 1);
        rst_n = 1'b0; run = 1'b0; #1;
        chk_quiet("rstmem");
        tick; rst_n = 1'b1; #1;
        tick; #1;
        chk("rstmem_idle_req", 32'(imem_req), 0);
        tick; #1;
        chk("rstmem_idle_req2", 32'(imem_req), 0);

        // Load timeout
        run = 1'b1; imem_ack = 1'b1;
        tick; tick; tick; #1;
        chk("lto_ex_src", 32'(alu_src_imm), 1);
        for (int k = 1; k <= 16; k++) begin
            tick; #1;
            chk("lto_dreq", 32'(dmem_req), 1);
            chk("lto_no_trap", 32'(trap), 0);
        end
        tick; #1;
        chk("lto_trap", 32'(trap), 1);
        chk("lto_cause", 32'(trap_cause), 3);
        chk("lto_dreq_off", 32'(dmem_req), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
